// File: rtl/kq_hp_dds_spi.sv
// kq_hp_dds_spi: loads uplink/downlink 48-bit FTWs into two DDS chips over a shared SPI bus.
// Each write is {instruction byte, FTW} MSB first, followed by an IO_UPDATE pulse on the same chip.
module kq_hp_dds_spi #(
  parameter int unsigned CLK_DIV    = 4,
  parameter logic [7:0]  FTW_INSTR  = 8'h01,
  parameter int unsigned IOUP_WIDTH = 8
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [47:0] uplink_ftw,
  input  logic        uplink_ftw_vld,
  input  logic [47:0] downlink_ftw,
  input  logic        downlink_ftw_vld,
  output logic        dds_sclk,
  output logic        dds_sdio,
  output logic [1:0]  dds_cs_n,
  output logic [1:0]  dds_io_update,
  output logic        busy,
  output logic        up_done,
  output logic        down_done
);

  // state | meaning
  // IDLE  | bus idle, waiting for a pending word
  // LOAD  | chip select asserted, first bit set up on sdio
  // SHIFT | 56 bits out, sclk high half then low half per bit
  // IOUP  | chip selects released, io_update high on selected chip
  // GAP   | bus spacing; done pulse in the first cycle
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_IOUP, S_GAP} state_t;

  localparam int HC_W = $clog2(CLK_DIV + 1);
  localparam int IU_W = $clog2(IOUP_WIDTH + 1);
  localparam logic [HC_W-1:0] HC_DIV  = HC_W'(CLK_DIV);
  localparam logic [IU_W-1:0] IU_LOAD = IU_W'(IOUP_WIDTH);

  state_t          state;
  logic            up_pend, dn_pend;
  logic [47:0]     up_word, dn_word;
  logic            next_dn, sel_dn;
  logic [55:0]     shift_reg;
  logic [HC_W-1:0] half_cnt;
  logic [5:0]      bit_cnt;
  logic [IU_W-1:0] ioup_cnt;
  logic            pick_dn, half_tc, start;

  always_comb begin
    pick_dn = dn_pend & (~up_pend | next_dn);
    half_tc = (half_cnt == HC_W'(1));
    start   = (up_pend | dn_pend) & ((state == S_IDLE) | ((state == S_GAP) & half_tc));
  end

  // Shift register drains to zero after 56 shifts, so sdio idles low without extra gating.
  assign dds_sdio = shift_reg[55];

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      up_pend       <= 1'b0;
      dn_pend       <= 1'b0;
      up_word       <= '0;
      dn_word       <= '0;
      next_dn       <= 1'b0;
      sel_dn        <= 1'b0;
      shift_reg     <= '0;
      half_cnt      <= '0;
      bit_cnt       <= '0;
      ioup_cnt      <= '0;
      dds_sclk      <= 1'b0;
      dds_cs_n      <= 2'b11;
      dds_io_update <= 2'b00;
      busy          <= 1'b0;
      up_done       <= 1'b0;
      down_done     <= 1'b0;
    end else begin
      up_done   <= 1'b0;
      down_done <= 1'b0;
      if (start) begin
        state         <= S_LOAD;
        sel_dn        <= pick_dn;
        next_dn       <= ~pick_dn;
        busy          <= 1'b1;
        half_cnt      <= HC_DIV;
        bit_cnt       <= 6'd55;
        dds_sclk      <= 1'b0;
        dds_io_update <= 2'b00;
        dds_cs_n      <= pick_dn ? 2'b01 : 2'b10;
        if (pick_dn) begin
          shift_reg <= {FTW_INSTR, dn_word};
          dn_pend   <= 1'b0;
        end else begin
          shift_reg <= {FTW_INSTR, up_word};
          up_pend   <= 1'b0;
        end
      end else begin
        case (state)
          S_LOAD: begin
            if (half_tc) begin
              state    <= S_SHIFT;
              dds_sclk <= 1'b1;
              half_cnt <= HC_DIV;
            end else begin
              half_cnt <= half_cnt - 1'b1;
            end
          end
          S_SHIFT: begin
            if (!half_tc) begin
              half_cnt <= half_cnt - 1'b1;
            end else if (dds_sclk) begin
              dds_sclk  <= 1'b0;
              shift_reg <= {shift_reg[54:0], 1'b0};
              half_cnt  <= HC_DIV;
            end else if (bit_cnt == 6'd0) begin
              state         <= S_IOUP;
              dds_cs_n      <= 2'b11;
              dds_io_update <= sel_dn ? 2'b10 : 2'b01;
              ioup_cnt      <= IU_LOAD;
            end else begin
              bit_cnt  <= bit_cnt - 1'b1;
              dds_sclk <= 1'b1;
              half_cnt <= HC_DIV;
            end
          end
          S_IOUP: begin
            if (ioup_cnt == IU_W'(1)) begin
              state         <= S_GAP;
              dds_io_update <= 2'b00;
              half_cnt      <= HC_DIV;
              up_done       <= ~sel_dn;
              down_done     <= sel_dn;
            end else begin
              ioup_cnt <= ioup_cnt - 1'b1;
            end
          end
          S_GAP: begin
            if (half_tc) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              half_cnt <= half_cnt - 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
      // Capture after the start logic so a same-cycle vld keeps the flag set.
      if (uplink_ftw_vld) begin
        up_word <= uplink_ftw;
        up_pend <= 1'b1;
      end
      if (downlink_ftw_vld) begin
        dn_word <= downlink_ftw;
        dn_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kq_hp_dds_spi.sv
// Scoreboard bench for kq_hp_dds_spi: stimulus queues expected frames, a pin-level monitor
// decodes SPI frames, IO_UPDATE, done pulses and busy time and compares them.
module tb_kq_hp_dds_spi;
  localparam int CD = 2;
  localparam int IW = 4;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] uplink_ftw = '0, downlink_ftw = '0;
  logic        uplink_ftw_vld = 1'b0, downlink_ftw_vld = 1'b0;
  logic        dds_sclk, dds_sdio, busy, up_done, down_done;
  logic [1:0]  dds_cs_n, dds_io_update;

  int errors = 0;
  int checks = 0;

  kq_hp_dds_spi #(.CLK_DIV(CD), .FTW_INSTR(8'h01), .IOUP_WIDTH(IW)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .uplink_ftw(uplink_ftw), .uplink_ftw_vld(uplink_ftw_vld),
    .downlink_ftw(downlink_ftw), .downlink_ftw_vld(downlink_ftw_vld),
    .dds_sclk(dds_sclk), .dds_sdio(dds_sdio), .dds_cs_n(dds_cs_n),
    .dds_io_update(dds_io_update), .busy(busy),
    .up_done(up_done), .down_done(down_done)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // {channel (0=up,1=down), 56-bit frame}
  logic [56:0] exp_q[$];

  task automatic push(input logic ch, input logic [47:0] w);
    exp_q.push_back({ch, 8'h01, w});
  endtask

  // Monitor state
  logic        in_frame = 1'b0, cur_ch = 1'b0, last_ch = 1'b0, overlap = 1'b0;
  logic        prev_sclk = 1'b0, prev_busy = 1'b0;
  logic [55:0] bits = '0;
  logic [56:0] e;
  int          rises = 0, cs_len = 0, iou_len = 0, busy_len = 0, run_frames = 0;
  int          frames = 0, dones = 0;

  always @(negedge sys_clk) begin
    if (!rst_n) begin
      in_frame = 1'b0; prev_sclk = 1'b0; prev_busy = 1'b0;
      busy_len = 0; run_frames = 0; iou_len = 0;
    end else begin
      if (!in_frame && dds_cs_n != 2'b11) begin
        in_frame = 1'b1; cur_ch = (dds_cs_n == 2'b01); bits = '0;
        rises = 0; cs_len = 0; overlap = 1'b0;
      end
      if (in_frame) begin
        if (dds_cs_n == 2'b11) begin
          in_frame = 1'b0;
          if (exp_q.size() == 0) begin
            check("frame_unexpected", {cur_ch, bits}, 57'h0);
          end else begin
            e = exp_q.pop_front();
            check("frame_data", {cur_ch, bits}, e);
            check("frame_rises", rises, 56);
            check("frame_cs_len", cs_len, 113 * CD);
            check("frame_overlap", overlap, 1'b0);
          end
          frames++; run_frames++; last_ch = cur_ch; iou_len = 0;
        end else begin
          cs_len++;
          if (dds_cs_n == 2'b00) overlap = 1'b1;
          if (dds_sclk && !prev_sclk) begin
            bits = {bits[54:0], dds_sdio};
            rises++;
          end
        end
      end
      if (dds_io_update != 2'b00) begin
        if (dds_io_update == (2'b01 << last_ch)) iou_len++;
        else iou_len = -1000;
      end
      if (up_done || down_done) begin
        check("done_chan", {down_done, up_done}, 2'b01 << last_ch);
        check("ioup_len", iou_len, IW);
        dones++;
      end
      if (busy) busy_len++;
      if (prev_busy && !busy) begin
        check("busy_len", busy_len, (113 * CD + IW + CD) * run_frames);
        busy_len = 0; run_frames = 0;
      end
      prev_busy = busy;
      prev_sclk = dds_sclk;
    end
  end

  task automatic tick();
    @(posedge sys_clk); #2;
  endtask

  task automatic pulse(input logic do_up, input logic [47:0] uw,
                       input logic do_dn, input logic [47:0] dw);
    tick();
    if (do_up) begin uplink_ftw = uw; uplink_ftw_vld = 1'b1; end
    if (do_dn) begin downlink_ftw = dw; downlink_ftw_vld = 1'b1; end
    tick();
    uplink_ftw_vld = 1'b0; downlink_ftw_vld = 1'b0;
  endtask

  task automatic wait_cs(input logic [1:0] target);
    logic found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (dds_cs_n == target) found = 1'b1;
    end
    check("wait_cs", found, 1'b1);
  endtask

  task automatic wait_idle();
    logic found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      tick();
      if (exp_q.size() == 0 && !busy) found = 1'b1;
    end
    check("wait_idle", found, 1'b1);
    repeat (3) tick();
  endtask

  initial begin
    int n;
    logic ps;
    repeat (4) tick();
    check("rst_outputs", {dds_cs_n, dds_sclk, dds_sdio, dds_io_update, busy, up_done, down_done},
          9'b11_0_0_00_0_0_0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Both channels at once after reset: uplink first, downlink back-to-back.
    push(1'b0, 48'hA5A5_0000_1111);
    push(1'b1, 48'hB00B_1234_5678);
    pulse(1'b1, 48'hA5A5_0000_1111, 1'b1, 48'hB00B_1234_5678);
    wait_idle();

    // Single uplink word: frame bytes 01 12 34 56 78 9A BC.
    exp_q.push_back({1'b0, 56'h01_1234_5678_9ABC});
    pulse(1'b1, 48'h1234_5678_9ABC, 1'b0, '0);
    wait_idle();

    // Two downlink words during an uplink frame: only the last is sent.
    push(1'b0, 48'h0F0F_0F0F_0F0F);
    pulse(1'b1, 48'h0F0F_0F0F_0F0F, 1'b0, '0);
    wait_cs(2'b10);
    pulse(1'b0, '0, 1'b1, 48'h0000_0000_0001);
    repeat (10) tick();
    exp_q.push_back({1'b1, 56'h01_0000_0000_0002});
    pulse(1'b0, '0, 1'b1, 48'h0000_0000_0002);
    wait_idle();

    // Uplink re-pulsed in the LOAD-entry cycle; also checks vld-to-cs_n latency.
    push(1'b0, 48'h1111_1111_1111);
    push(1'b0, 48'h2222_2222_2222);
    tick();
    uplink_ftw = 48'h1111_1111_1111; uplink_ftw_vld = 1'b1;
    tick();
    uplink_ftw = 48'h2222_2222_2222;
    tick();
    uplink_ftw_vld = 1'b0;
    check("vld_to_cs", dds_cs_n, 2'b10);
    wait_idle();

    // Reset mid-SHIFT of an uplink frame.
    pulse(1'b1, 48'hFFFF_0000_FFFF, 1'b0, '0);
    n = 0; ps = 1'b0;
    for (int i = 0; i < 1000 && n < 21; i++) begin
      tick();
      if (dds_sclk && !ps) n++;
      ps = dds_sclk;
    end
    check("reach_bit20", n, 21);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_cs", dds_cs_n, 2'b11);
    check("rst_mid_other", {dds_sclk, dds_sdio, dds_io_update, busy, up_done, down_done}, 7'b0);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (dds_cs_n != 2'b11 || dds_io_update != 2'b00 || busy || up_done || down_done) n++;
    end
    check("no_restart", n, 0);

    // Alternating load: order U1 D1 U2 D2 U3 with ties resolved round-robin.
    push(1'b0, 48'h0000_0000_0A01);
    push(1'b1, 48'h0000_0000_0D01);
    pulse(1'b1, 48'h0000_0000_0A01, 1'b1, 48'h0000_0000_0D01);
    wait_cs(2'b01);
    push(1'b0, 48'h0000_0000_0A02);
    push(1'b1, 48'h0000_0000_0D02);
    pulse(1'b1, 48'h0000_0000_0A02, 1'b1, 48'h0000_0000_0D02);
    wait_cs(2'b10);
    push(1'b0, 48'h0000_0000_0A03);
    pulse(1'b1, 48'h0000_0000_0A03, 1'b0, '0);
    wait_idle();

    check("queue_empty", exp_q.size(), 0);
    check("dones_vs_frames", dones, frames);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/kq_hp_dds_spi.md
# kq_hp_dds_spi

Serial writer that takes the 48-bit uplink and downlink frequency tuning words produced by the FTW calculation stage and loads them into two DDS devices. Each device has its own chip select and IO_UPDATE line and shares SCLK/SDIO with the other. Each word is sent as one SPI mode-0 write frame: an instruction byte followed by the 48-bit FTW, MSB first. An IO_UPDATE pulse then commits the word. Sits directly downstream of the FTW stage, in the sys_clk domain, and drives the DDS pins.

## Interface
- CLK_DIV, 4: SCLK half-period in sys_clk cycles; legal range is 1 or more.
- FTW_INSTR, 8'h01: instruction byte sent before every FTW (write, FTW register address).
- IOUP_WIDTH, 8: IO_UPDATE high time in sys_clk cycles; legal range is 1 or more.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- uplink_ftw  in  48  uplink tuning word.
- uplink_ftw_vld  in  1  single-cycle qualifier for uplink_ftw.
- downlink_ftw  in  48  downlink tuning word.
- downlink_ftw_vld  in  1  single-cycle qualifier for downlink_ftw.
- dds_sclk  out  1  SPI clock; idles low.
- dds_sdio  out  1  SPI data; the DDS samples it on the SCLK rising edge.
- dds_cs_n  out  2  chip selects, active-low; bit 0 is uplink, bit 1 is downlink.
- dds_io_update  out  2  IO_UPDATE pulses; bit 0 is uplink, bit 1 is downlink.
- busy  out  1  high while a frame, its IO_UPDATE or its gap is in progress.
- up_done  out  1  one-cycle pulse when an uplink write completes.
- down_done  out  1  one-cycle pulse when a downlink write completes.

## Operation
- Each channel has a pending flag and a 48-bit holding register.
- Capture: a vld pulse stores the word and sets the pending flag.
  - A vld while the channel is pending but its frame has not started overwrites the held word. Last value wins; no error is flagged.
  - Words arriving during that channel's own frame are held and sent afterwards.
- Start of a frame: the FSM enters LOAD for a channel. On that entry it copies {FTW_INSTR, word} into a 56-bit shift register and clears the channel's pending flag.
  - If a vld for the same channel arrives in that same cycle, the new word is captured and the flag stays set.
- Arbitration is round-robin. If both channels are pending in IDLE, the channel not served last wins. After reset, uplink is treated as the next to serve.
- FSM states:
  - IDLE: busy=0. Moves to LOAD when any channel is pending.
  - LOAD: CLK_DIV cycles. Selected cs_n low, sclk low, sdio = shift bit 55.
  - SHIFT: 56 bits, each taking 2·CLK_DIV cycles.
    - First half of each bit: sclk high.
    - Second half: sclk low; at the start of the low half, sdio advances to the next bit.
    - After bit 0, sdio is 0.
    - After the 56th low half, go to IOUP.
  - IOUP: IOUP_WIDTH cycles. All cs_n high; selected io_update high.
  - GAP: CLK_DIV cycles with all outputs idle. The done pulse for the selected channel is high in the first GAP cycle. Then IDLE.
- Only one cs_n bit is ever low at a time.
- Bit counter: 6 bits. Half-period counter: sized for CLK_DIV. IOUP counter: sized for IOUP_WIDTH.
- Reset (any state, including mid-frame) takes effect on the next edge:
  - FSM returns to IDLE; pending flags are cleared; round-robin returns to uplink-next.
  - Outputs go to dds_cs_n=2'b11, dds_sclk=0, dds_sdio=0, dds_io_update=0, busy=0, up_done=0, down_done=0.
  - An aborted frame is not resumed.

## Timing
- Reset values: cs_n=2'b11, all other outputs 0.
- From a vld sampled at edge E0 to cs_n low: the pending flag sets at E0 and LOAD is entered at E1, so cs_n is low after E1.
- Frame length: CLK_DIV + 112·CLK_DIV cycles with cs_n low.
- Bus timing:
  - Setup from sdio to the SCLK rise is at least CLK_DIV cycles.
  - Hold after the final SCLK fall before cs_n rises is CLK_DIV cycles.
- Total busy time per write: 113·CLK_DIV + IOUP_WIDTH + CLK_DIV cycles.
- busy goes high on LOAD entry and low on IDLE entry.
- Back-to-back writes: the next LOAD starts the cycle after GAP ends. No IDLE cycle is inserted when something is pending.

## Test plan
- CLK_DIV=2, IOUP_WIDTH=4; uplink_ftw=48'h123456789ABC with one vld pulse.
  - cs_n[0] low for 226 cycles; 56 SCLK rises.
  - Bits sampled on the rises are 01 12 34 56 78 9A BC.
  - io_update[0] high for 4 cycles, then up_done for 1 cycle; busy high for 232 cycles.
- Uplink and downlink vld pulsed in the same cycle (A..., B...).
  - Uplink frame first, then downlink frame immediately after GAP.
  - cs_n[1] never overlaps cs_n[0].
- During an uplink frame, downlink vld pulses twice, with 48'h1 then 48'h2.
  - Exactly one downlink frame follows, carrying 48'h000000000002.
- Uplink vld pulsed again in the LOAD-entry cycle of the uplink frame.
  - The current frame sends the old word.
  - A second uplink frame with the new word follows.
- rst_n low for 1 cycle during SHIFT bit 20.
  - Next cycle: cs_n=2'b11, sclk=0, sdio=0, busy=0, no done pulse, no io_update.
  - No frame restarts until a new vld.
- Alternating load: both channels continuously re-pended.
  - Service order strictly alternates U, D, U, D.
